// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data_mem: stores queue in a small FIFO and retire
// in the background; loads drain the FIFO, then run one read transaction (strict program order).
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  typedef enum logic [2:0] {RST_WAIT, IDLE, ST_HI, ST_LO, LD_HI, LD_LO, LD_DONE} state_t;

  state_t           state, state_d;
  entry_t           fifo [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, stall_load, push, pop;
  logic [31:0]      mem_addr_d, mem_write_data_d, cpu_read_data_d;
  logic [3:0]       mem_sign_mask_d;
  logic             mem_memwrite_d, mem_memread_d;

  assign head       = fifo[rd_ptr];
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign stall_load = cpu_memread && (state != LD_DONE);
  assign cpu_stall  = (cpu_memwrite && full) || stall_load;
  // A simultaneous write+read request is handled as a load only.
  assign push       = cpu_memwrite && !cpu_memread && !full && !stall_load;

  always_ff @(posedge clk) begin
    if (reset) state <= RST_WAIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d          = state;
    pop              = 1'b0;
    mem_addr_d       = mem_addr;
    mem_write_data_d = mem_write_data;
    mem_sign_mask_d  = mem_sign_mask;
    mem_memwrite_d   = 1'b0;
    mem_memread_d    = 1'b0;
    cpu_read_data_d  = cpu_read_data;
    case (state)
      RST_WAIT: if (!mem_clk_stall) state_d = IDLE;
      IDLE: begin
        // Queued stores win over a pending load: drain before load.
        if (count != '0) begin
          mem_addr_d       = head.addr;
          mem_write_data_d = head.data;
          mem_sign_mask_d  = head.mask;
          mem_memwrite_d   = 1'b1;
          pop              = 1'b1;
          state_d          = ST_HI;
        end else if (cpu_memread) begin
          mem_addr_d      = cpu_addr;
          mem_sign_mask_d = cpu_sign_mask;
          mem_memread_d   = 1'b1;
          state_d         = LD_HI;
        end
      end
      ST_HI:   if (mem_clk_stall) state_d = ST_LO;
      ST_LO:   if (!mem_clk_stall) state_d = IDLE;
      LD_HI:   if (mem_clk_stall) state_d = LD_LO;
      LD_LO: begin
        if (!mem_clk_stall) begin
          cpu_read_data_d = mem_read_data;
          state_d         = LD_DONE;
        end
      end
      LD_DONE: state_d = IDLE;
      default: state_d = RST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{addr: cpu_addr, data: cpu_write_data, mask: cpu_sign_mask};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_sign_mask  <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      cpu_read_data  <= '0;
    end else begin
      mem_addr       <= mem_addr_d;
      mem_write_data <= mem_write_data_d;
      mem_sign_mask  <= mem_sign_mask_d;
      mem_memwrite   <= mem_memwrite_d;
      mem_memread    <= mem_memread_d;
      cpu_read_data  <= cpu_read_data_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random store/load traffic against a
// behavioural program-order memory model and a downstream data_mem model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
  logic        cpu_memwrite, cpu_memread, cpu_stall;
  logic [3:0]  cpu_sign_mask, mem_sign_mask;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
    .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;

  int          n_vec = 0;
  int          n_err = 0;
  txn_t        exp_q [$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] tb_mem  [logic [31:0]];
  int          busy_q = 0;
  int          fixed_lat = 2;
  int          lat_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // data_mem model: accepts a pulse, stays busy for a latency, does the access at accept time
  assign mem_clk_stall = (busy_q != 0);
  always @(posedge clk) begin
    if (busy_q != 0) busy_q <= busy_q - 1;
    else if (mem_memwrite || mem_memread) begin
      lat_v = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
      busy_q <= lat_v;
      if (mem_memwrite) tb_mem[mem_addr] = mem_write_data;
      else mem_read_data <= tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : 32'h0;
    end
  end

  // Every downstream request pulse must match the next expected transaction in program order.
  always @(negedge clk) begin
    if (!reset && (mem_memwrite || mem_memread)) begin
      check("pulse_excl", 64'(mem_memwrite & mem_memread), 64'h0);
      if (exp_q.size() == 0) check("unexp_pulse", 64'({mem_memwrite, mem_memread}), 64'h0);
      else begin
        txn_t t;
        t = exp_q.pop_front();
        check("pulse_kind", 64'(mem_memwrite), 64'(t.wr));
        check("pulse_addr", 64'(mem_addr), 64'(t.addr));
        check("pulse_mask", 64'(mem_sign_mask), 64'(t.mask));
        if (t.wr) check("pulse_data", 64'(mem_write_data), 64'(t.data));
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int st);
    bit ok = 0;
    st = 0;
    cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
    cpu_memwrite = 1'b1; cpu_memread = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1; break; end
      st++;
      @(posedge clk); #1;
    end
    check("st_timeout", 64'(ok), 64'h1);
    if (ok) begin
      exp_q.push_back('{1'b1, a, d, m});
      ref_mem[a] = d;
    end
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, input bit both,
                         output int st);
    bit ok = 0;
    logic [31:0] want;
    want = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    st = 0;
    cpu_addr = a; cpu_sign_mask = m; cpu_write_data = $urandom;
    cpu_memread = 1'b1; cpu_memwrite = both;
    exp_q.push_back('{1'b0, a, 32'h0, m});
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1; break; end
      st++;
      @(posedge clk); #1;
    end
    check("ld_timeout", 64'(ok), 64'h1);
    if (ok) check("ld_data", 64'(cpu_read_data), 64'(want));
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mem_clk_stall) break;
    end
    check("drain", 64'(exp_q.size()), 64'h0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    logic [31:0] a;
    reset = 1'b1;
    cpu_addr = '0; cpu_write_data = '0; cpu_memwrite = 1'b0; cpu_memread = 1'b0;
    cpu_sign_mask = '0; mem_read_data = '0;
    tb_mem[32'h1004] = 32'hDEADBEEF;
    ref_mem[32'h1004] = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memwrite", 64'(mem_memwrite), 64'h0);
    check("rst_memread", 64'(mem_memread), 64'h0);
    check("rst_addr", 64'(mem_addr), 64'h0);
    check("rst_wdata", 64'(mem_write_data), 64'h0);
    check("rst_mask", 64'(mem_sign_mask), 64'h0);
    check("rst_rdata", 64'(cpu_read_data), 64'h0);
    check("rst_stall", 64'(cpu_stall), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Load from empty buffer: cycle-accurate latency
    cpu_addr = 32'h1004; cpu_sign_mask = 4'hF; cpu_memread = 1'b1;
    exp_q.push_back('{1'b0, 32'h1004, 32'h0, 4'hF});
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("ld_stall_c%0d", c), 64'(cpu_stall), 64'(c < 5));
      check($sformatf("ld_pulse_c%0d", c), 64'(mem_memread), 64'(c == 1));
      if (c == 5) check("ld_deadbeef", 64'(cpu_read_data), 64'hDEADBEEF);
      @(posedge clk); #1;
    end
    cpu_memread = 1'b0;
    wait_drain();

    // Five back-to-back stores behind a slow in-flight store: the fifth must stall
    fixed_lat = 8;
    do_store(32'h0F00, 32'h0BAD0F00, 4'hF, st);
    for (int i = 0; i < 5; i++) begin
      do_store(32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 4'hF, st);
      check($sformatf("b2b_stall_%0d", i), 64'(st > 0), 64'(i == 4));
    end
    fixed_lat = 2;
    wait_drain();

    // Store then immediate load of the same address
    do_store(32'h1008, 32'h12345678, 4'hF, st);
    do_load(32'h1008, 4'hF, 1'b0, st);
    check("ld_after_st_waited", 64'(st > 5), 64'h1);
    wait_drain();

    // Byte store: mask/address visible on the pulse
    do_store(32'h1001, 32'h000000AB, 4'b0001, st);
    wait_drain();

    // LED store never stalls and lands downstream
    do_store(32'h2000, 32'h5A, 4'hF, st);
    check("led_nostall", 64'(st), 64'h0);
    wait_drain();
    check("led_value", 64'(tb_mem.exists(32'h2000) ? tb_mem[32'h2000] : 32'h0), 64'h5A);

    // Reset while the load is in LD_LO with two stores queued
    fixed_lat = 4;
    cpu_addr = 32'h4000; cpu_sign_mask = 4'hF; cpu_memread = 1'b1;
    exp_q.push_back('{1'b0, 32'h4000, 32'h0, 4'hF});
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b1;
    cpu_addr = 32'h4100; cpu_write_data = 32'h11111111;
    @(posedge clk); #1;
    cpu_addr = 32'h4104; cpu_write_data = 32'h22222222;
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    check("rst_mid_count_before", 64'(dut.count), 64'h2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_count_after", 64'(dut.count), 64'h0);
    check("rst_mid_memread", 64'(mem_memread), 64'h0);
    check("rst_mid_busy", 64'(mem_clk_stall), 64'h1);
    repeat (5) @(posedge clk);
    #1;
    fixed_lat = 2;
    do_load(32'h4100, 4'hF, 1'b0, st);
    check("rst_mid_idle_latency", 64'(st), 64'h5);
    wait_drain();

    // Random traffic against the program-order reference
    fixed_lat = 0;
    for (int n = 0; n < 200; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = 32'h3000 + 32'(4 * $urandom_range(0, 7));
      if (r < 5)       do_store(a, $urandom, 4'($urandom), st);
      else if (r < 8)  do_load(a, 4'($urandom), 1'b0, st);
      else if (r == 8) do_load(a, 4'($urandom), 1'b1, st);
      else begin @(posedge clk); #1; end
    end
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
